// File: rtl/ama_riscv_fetch_unit_pkg.sv
// Shared fetch-path constants (the former ama_riscv_defines.v): NOP encoding,
// default reset PC and default fetch-queue depth.
package ama_riscv_fetch_unit_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/ama_riscv_fetch_unit_sync_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and combinational head.
// DEPTH must be a power of two so the pointers wrap naturally.
module ama_riscv_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    assign head = mem[rd_ptr];

    // Storage is not reset; validity is tracked solely by count.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ama_riscv_fetch_unit.sv
// Decoupled instruction-fetch front end: credit-based IMEM issue, fetch queue,
// redirect flush with in-flight drop. `FETCH_BYPASS_EN enables the 1-cycle bypass.
module ama_riscv_fetch_unit
    import ama_riscv_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     IMEM_AW  = 14,
    parameter int unsigned     FQ_DEPTH = FQ_DEPTH_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           redirect_valid,
    input  logic [XLEN-1:0]                redirect_pc,
    output logic                           imem_req,
    output logic [IMEM_AW-1:0]             imem_addr,
    input  logic [31:0]                    imem_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_inst,
    output logic [XLEN-1:0]                out_pc,
    output logic [$clog2(FQ_DEPTH+1)-1:0]  fq_count
);

    localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
    localparam int unsigned EW = 32 + XLEN;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic            drop;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            resp_valid;
    logic            q_push;
    logic            q_pop;
    logic            q_empty;
    logic [EW-1:0]   q_head;
    logic            unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Credits count queued entries plus the response still on its way.
    assign occupancy  = {1'b0, fq_count} + {{CW{1'b0}}, inflight};
    assign issue      = !rst && !redirect_valid && (occupancy < (CW+1)'(FQ_DEPTH));
    assign imem_req   = issue;
    assign imem_addr  = fetch_pc[IMEM_AW+1:2];
    assign resp_valid = inflight && !drop;
    assign q_empty    = (fq_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            inflight <= 1'b0;
            drop     <= inflight;
        end else begin
            drop     <= 1'b0;
            inflight <= issue;
            if (issue) begin
                fetch_pc    <= fetch_pc + XLEN'(4);
                inflight_pc <= fetch_pc;
            end
        end
    end

`ifdef FETCH_BYPASS_EN
    // An accepted response on an empty queue goes straight to decode and is never written.
    assign q_push = resp_valid && !redirect_valid && !(q_empty && out_ready);
`else
    assign q_push = resp_valid && !redirect_valid;
`endif

    always_comb begin
        out_valid = 1'b0;
        out_inst  = NOP;
        out_pc    = '0;
        if (!redirect_valid) begin
            if (!q_empty) begin
                out_valid = 1'b1;
                out_inst  = q_head[EW-1:XLEN];
                out_pc    = q_head[XLEN-1:0];
            end
`ifdef FETCH_BYPASS_EN
            else if (resp_valid) begin
                out_valid = 1'b1;
                out_inst  = imem_rdata;
                out_pc    = inflight_pc;
            end
`endif
        end
    end

    assign q_pop = out_valid && out_ready && !q_empty;

    ama_riscv_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (q_push),
        .pop       (q_pop),
        .push_data ({imem_rdata, inflight_pc}),
        .head      (q_head),
        .count     (fq_count)
    );

endmodule

// File: tb/tb_ama_riscv_fetch_unit.sv
// Directed self-checking bench for ama_riscv_fetch_unit; IMEM word i holds i.
// Expected latencies follow FETCH_BYPASS_EN when the bench is built with it.
module tb_ama_riscv_fetch_unit;

`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    localparam logic [31:0] NOP_I = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [2:0]  fq_count;

    int vectors = 0;
    int miscompares = 0;

    ama_riscv_fetch_unit #(
        .XLEN     (32),
        .IMEM_AW  (14),
        .FQ_DEPTH (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .fq_count       (fq_count)
    );

    always #5 clk = ~clk;

    // 1-cycle synchronous IMEM; garbage when not requested
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= {18'b0, imem_addr};
        else          imem_rdata <= 32'hDEAD_BEEF;
    end

    // Holds rst for two edges, returns at the negedge starting the first rst-low cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1; redirect_valid = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req_comb got %b exp 0", imem_req); end
        @(negedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        vectors++; if (out_inst !== NOP_I) begin miscompares++; $display("FAIL rst_inst got %h exp %h", out_inst, NOP_I); end
        vectors++; if (out_pc !== 32'h0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", out_pc); end
        vectors++; if (fq_count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", fq_count); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got %b exp 0", imem_req); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'd0) begin miscompares++; $display("FAIL rst_first_req got %b/%h exp 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'(k)) begin miscompares++; $display("FAIL stream_req k=%0d got %b/%h exp 1/%h", k, imem_req, imem_addr, 14'(k)); end
            vectors++; if (out_valid !== (k >= LAT)) begin miscompares++; $display("FAIL stream_valid k=%0d got %b exp %b", k, out_valid, (k >= LAT)); end
            if (k >= LAT) begin
                vectors++; if (out_pc !== 32'(4 * (k - LAT)) || out_inst !== 32'(k - LAT)) begin miscompares++; $display("FAIL stream_data k=%0d got %h/%h exp %h/%h", k, out_pc, out_inst, 32'(4 * (k - LAT)), 32'(k - LAT)); end
            end else begin
                vectors++; if (out_pc !== 32'h0 || out_inst !== NOP_I) begin miscompares++; $display("FAIL stream_idle k=%0d got %h/%h exp 0/%h", k, out_pc, out_inst, NOP_I); end
            end
        end
    endtask

    task automatic test_backpressure();
        int exp_idx;
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            vectors++; if (fq_count > 3'd4) begin miscompares++; $display("FAIL bp_overflow k=%0d got %0d exp <=4", k, fq_count); end
        end
        vectors++; if (fq_count !== 3'd4) begin miscompares++; $display("FAIL bp_full got %0d exp 4", fq_count); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_req_stall got %b exp 0", imem_req); end
        exp_idx = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk); out_ready = 1'b1; #1;
            if (out_valid) begin
                vectors++; if (out_pc !== 32'(4 * exp_idx) || out_inst !== 32'(exp_idx)) begin miscompares++; $display("FAIL bp_order got %h/%h exp %h/%h", out_pc, out_inst, 32'(4 * exp_idx), 32'(exp_idx)); end
                exp_idx++;
            end
        end
        vectors++; if (exp_idx !== 16) begin miscompares++; $display("FAIL bp_delivered got %0d exp 16", exp_idx); end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
        end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h100; #1;
        vectors++; if (fq_count !== 3'd3) begin miscompares++; $display("FAIL redir_pre_count got %0d exp 3", fq_count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_valid got %b exp 0", out_valid); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req got %b exp 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0; out_ready = 1'b1; #1;
        vectors++; if (fq_count !== 3'd0) begin miscompares++; $display("FAIL redir_flush got %0d exp 0", fq_count); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL redir_drop got %b exp 0", out_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'h40) begin miscompares++; $display("FAIL redir_newreq got %b/%h exp 1/40", imem_req, imem_addr); end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk); #1;
            vectors++; if (out_valid !== (k >= 1 + LAT)) begin miscompares++; $display("FAIL redir_lat k=%0d got %b exp %b", k, out_valid, (k >= 1 + LAT)); end
            if (k >= 1 + LAT) begin
                vectors++; if (out_pc !== 32'h100 + 32'(4 * (k - 1 - LAT)) || out_inst !== 32'h40 + 32'(k - 1 - LAT)) begin miscompares++; $display("FAIL redir_data k=%0d got %h/%h", k, out_pc, out_inst); end
            end
        end
    endtask

    task automatic test_misaligned_wrap();
        logic [31:0] ep;
        do_reset();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req got %b exp 0", imem_req); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'h40) begin miscompares++; $display("FAIL mis_align got %b/%h exp 1/40", imem_req, imem_addr); end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_redir_valid got %b exp 0", out_valid); end
        for (int k = 1; k < 5; k++) begin
            @(negedge clk); redirect_valid = 1'b0; #1;
            if (k == 1) begin
                vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'h3FFF) begin miscompares++; $display("FAIL wrap_req1 got %b/%h exp 1/3fff", imem_req, imem_addr); end
            end
            if (k == 2) begin
                vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'h0) begin miscompares++; $display("FAIL wrap_req2 got %b/%h exp 1/0", imem_req, imem_addr); end
            end
            vectors++; if (out_valid !== (k >= 1 + LAT)) begin miscompares++; $display("FAIL wrap_valid k=%0d got %b exp %b", k, out_valid, (k >= 1 + LAT)); end
            if (k >= 1 + LAT) begin
                ep = 32'hFFFF_FFFC + 32'(4 * (k - 1 - LAT));
                vectors++; if (out_pc !== ep || out_inst !== {18'b0, ep[15:2]}) begin miscompares++; $display("FAIL wrap_data k=%0d got %h/%h exp %h/%h", k, out_pc, out_inst, ep, {18'b0, ep[15:2]}); end
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
        end
        @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h200; #1;
        vectors++; if (fq_count !== 3'(LAT - 1)) begin miscompares++; $display("FAIL sim_pre_count got %0d exp %0d", fq_count, LAT - 1); end
        vectors++; if ((out_valid && out_ready) !== 1'b0) begin miscompares++; $display("FAIL sim_handshake got %b exp 0", out_valid && out_ready); end
        @(negedge clk); redirect_valid = 1'b0; #1;
        vectors++; if (fq_count !== 3'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL sim_empty got %0d/%b exp 0/0", fq_count, out_valid); end
        for (int k = 2; k < 4; k++) begin
            @(negedge clk); #1;
            vectors++; if (out_valid !== (k >= 1 + LAT)) begin miscompares++; $display("FAIL sim_valid k=%0d got %b exp %b", k, out_valid, (k >= 1 + LAT)); end
            if (k >= 1 + LAT) begin
                vectors++; if (out_pc !== 32'h200 + 32'(4 * (k - 1 - LAT))) begin miscompares++; $display("FAIL sim_pc k=%0d got %h", k, out_pc); end
            end
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
        end
        @(negedge clk); rst = 1'b1; #1;
        vectors++; if (fq_count !== 3'd3 || imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_pre got %0d/%b exp 3/0", fq_count, imem_req); end
        @(negedge clk); out_ready = 1'b1; #1;
        vectors++; if (fq_count !== 3'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_state got %0d/%b exp 0/0", fq_count, out_valid); end
        vectors++; if (out_inst !== NOP_I || out_pc !== 32'h0) begin miscompares++; $display("FAIL mid_rst_out got %h/%h exp %h/0", out_inst, out_pc, NOP_I); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 14'd0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_restart got %b/%h/%b exp 1/0/0", imem_req, imem_addr, out_valid); end
        for (int k = 1; k < 3; k++) begin
            @(negedge clk); #1;
            vectors++; if (out_valid !== (k >= LAT)) begin miscompares++; $display("FAIL mid_valid k=%0d got %b exp %b", k, out_valid, (k >= LAT)); end
            if (k >= LAT) begin
                vectors++; if (out_pc !== 32'(4 * (k - LAT)) || out_inst !== 32'(k - LAT)) begin miscompares++; $display("FAIL mid_data k=%0d got %h/%h", k, out_pc, out_inst); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_misaligned_wrap();
        test_simultaneous();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
